crotchet_sequencer: RTL



---
 rtl/crotchet_sequencer.sv | 138 +++++++++++++
 1 files changed

// File: rtl/crotchet_sequencer.sv
// Master beat generator: divides clk into semiquaver ticks, counts crotchets through
// the song, and runs a small start/pause/restart/end-of-song control FSM.
module crotchet_sequencer #(
    parameter int CLKS_PER_TICK = 5460000,
    parameter int NUM_CROTCHETS = 104,
    parameter int LOOP          = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       pause,
    input  logic       restart,
    output logic [6:0] crotchet,
    output logic       crotchet_pulse,
    output logic [1:0] semiquaver,
    output logic       semiquaver_pulse,
    output logic       phrase_pulse,
    output logic       playing,
    output logic       song_done
);

    localparam int TW = (CLKS_PER_TICK > 1) ? $clog2(CLKS_PER_TICK) : 1;
    localparam logic [TW-1:0] TICK_LAST     = TW'(CLKS_PER_TICK - 1);
    localparam logic [6:0]    LAST_CROTCHET = 7'(NUM_CROTCHETS - 1);
    localparam bit            STOP_AT_END   = (LOOP == 0);

    typedef enum logic [1:0] {
        IDLE,
        PLAY,
        PAUSE,
        DONE
    } state_t;

    state_t state, state_next;

    logic [TW-1:0] tick_cnt;
    logic          launch;
    logic          advance;
    logic          tick_term;
    logic          last_crotchet;
    logic          song_end;
    logic [6:0]    crotchet_next;

    assign tick_term     = (tick_cnt == TICK_LAST);
    assign last_crotchet = (crotchet == LAST_CROTCHET);
    assign song_end      = STOP_AT_END && tick_term && (semiquaver == 2'd3) && last_crotchet;
    assign crotchet_next = last_crotchet ? 7'd0 : crotchet + 7'd1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // restart outranks pause, which outranks start; a paused cycle never takes a tick
    always_comb begin
        state_next = state;
        launch     = 1'b0;
        advance    = 1'b0;
        if (restart) begin
            state_next = PLAY;
            launch     = 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (start && !pause) begin
                        state_next = PLAY;
                        launch     = 1'b1;
                    end
                end
                PLAY: begin
                    if (pause) begin
                        state_next = PAUSE;
                    end else begin
                        advance = 1'b1;
                        if (song_end) begin
                            state_next = DONE;
                        end
                    end
                end
                PAUSE: begin
                    if (start && !pause) begin
                        state_next = PLAY;
                    end
                end
                DONE: begin
                    state_next = DONE;
                end
                default: begin
                    state_next = IDLE;
                end
            endcase
        end
    end

    // On the final tick of a non-looping song everything holds, so DONE shows the last crotchet
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tick_cnt         <= '0;
            semiquaver       <= 2'd0;
            crotchet         <= 7'd0;
            semiquaver_pulse <= 1'b0;
            crotchet_pulse   <= 1'b0;
            phrase_pulse     <= 1'b0;
        end else begin
            semiquaver_pulse <= 1'b0;
            crotchet_pulse   <= 1'b0;
            phrase_pulse     <= 1'b0;
            if (launch) begin
                tick_cnt         <= '0;
                semiquaver       <= 2'd0;
                crotchet         <= 7'd0;
                semiquaver_pulse <= 1'b1;
                crotchet_pulse   <= 1'b1;
                phrase_pulse     <= 1'b1;
            end else if (advance) begin
                if (!tick_term) begin
                    tick_cnt <= tick_cnt + 1'b1;
                end else if (!song_end) begin
                    tick_cnt         <= '0;
                    semiquaver       <= semiquaver + 2'd1;
                    semiquaver_pulse <= 1'b1;
                    if (semiquaver == 2'd3) begin
                        crotchet       <= crotchet_next;
                        crotchet_pulse <= 1'b1;
                        phrase_pulse   <= (crotchet_next[2:0] == 3'd0);
                    end
                end
            end
        end
    end

    assign playing   = (state == PLAY);
    assign song_done = (state == DONE);

endmodule
